tx_skp_inserter: RTL and testbench

Upstream stage of the PHY TX path. Accepts the link-layer byte/K stream through a valid/ready handshake and produces a continuous one-symbol-per-cycle stream (data byte, is_control, com) for the scrambler/8b10b stage, which has no backpressure. Fills gaps with logical idle (D0.0). Every SKP_INTERVAL symbols it inserts a SKP ordered set of SKP_LEN K28.1 symbols, stalling upstream while the set is sent.

---
 rtl/usb3_tx_pkg.sv | 33 +++
 rtl/tx_skp_inserter.sv | 140 ++++++++++++++
 tb/tb_tx_skp_inserter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb3_tx_pkg.sv
// Shared definitions for the USB3 PHY transmit path.
//
// Contents:
//   K28_5, K28_1, IDLE_BYTE : symbol byte values
//   tx_state_e              : symbol-generator state
//   sym_t                   : one registered output symbol (byte + flags)
//   SYM_OFF/IDLE/SKP/COM    : canned symbols used by the generator
package usb3_tx_pkg;

    localparam logic [7:0] K28_5     = 8'hBC;  // COM
    localparam logic [7:0] K28_1     = 8'h3C;  // SKP
    localparam logic [7:0] IDLE_BYTE = 8'h00;  // logical idle, D0.0

    typedef enum logic [1:0] {
        ST_OFF,
        ST_DATA,
        ST_SKP
    } tx_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       is_control;
        logic       com;
        logic       valid;
        logic       skp_active;
    } sym_t;

    localparam sym_t SYM_OFF  = '{data: IDLE_BYTE, is_control: 1'b0, com: 1'b0, valid: 1'b0, skp_active: 1'b0};
    localparam sym_t SYM_IDLE = '{data: IDLE_BYTE, is_control: 1'b0, com: 1'b0, valid: 1'b1, skp_active: 1'b0};
    localparam sym_t SYM_SKP  = '{data: K28_1,     is_control: 1'b1, com: 1'b0, valid: 1'b1, skp_active: 1'b1};
    localparam sym_t SYM_COM  = '{data: K28_5,     is_control: 1'b1, com: 1'b1, valid: 1'b1, skp_active: 1'b1};

endpackage

// File: rtl/tx_skp_inserter.sv
// SKP ordered-set inserter for the PHY transmit path.
//
// Turns the link-layer valid/ready byte stream into a gap-free stream of one
// symbol per clock for the scrambler/8b10b stage. Gaps are filled with logical
// idle; every SKP_INTERVAL non-SKP symbols a SKP ordered set is sent while
// upstream is stalled.
//
// Optional feature (macro SKP_COM_PREFIX_EN): each SKP set is preceded by one
// COM symbol, making the set 1+SKP_LEN symbols long.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   tx_en           : enable symbol generation
//   up_data/up_k    : upstream byte and its K flag
//   up_valid        : upstream byte valid
//   up_ready        : byte accepted this cycle (combinational)
//   tx_data         : registered output symbol byte
//   tx_is_control   : output symbol is a K symbol
//   tx_com          : output symbol is COM (resets scrambler LFSR)
//   tx_valid        : output symbol valid
//   skp_active      : output symbol belongs to a SKP set
module tx_skp_inserter
    import usb3_tx_pkg::*;
#(
    parameter int SKP_INTERVAL = 354,
    parameter int SKP_LEN      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic [7:0] up_data,
    input  logic       up_k,
    input  logic       up_valid,
    output logic       up_ready,
    output logic [7:0] tx_data,
    output logic       tx_is_control,
    output logic       tx_com,
    output logic       tx_valid,
    output logic       skp_active
);

    localparam int CNT_W = $clog2(SKP_INTERVAL + 1);
    localparam int IDX_W = (SKP_LEN > 1) ? $clog2(SKP_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SKP_INTERVAL);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SKP_LEN - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [IDX_W-1:0] skp_idx_q, skp_idx_d;
    sym_t             sym_q, sym_d;
    logic             transfer;

    // Upstream is stalled for the whole SKP set, including the DATA cycle
    // that launches it (sym_cnt == SKP_INTERVAL).
    assign up_ready = !rst && tx_en && (state_q == ST_DATA) && (sym_cnt_q != CNT_MAX);
    assign transfer = up_valid && up_ready;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        sym_cnt_d = sym_cnt_q;
        skp_idx_d = skp_idx_q;
        sym_d     = SYM_OFF;

        unique case (state_q)
            ST_OFF: begin
                if (tx_en) state_d = ST_DATA;
            end

            ST_DATA: begin
                if (!tx_en) begin
                    state_d = ST_OFF;
                end else if (sym_cnt_q == CNT_MAX) begin
                    sym_cnt_d = '0;
`ifdef SKP_COM_PREFIX_EN
                    // COM goes out here; all SKP_LEN K28.1 symbols follow.
                    sym_d     = SYM_COM;
                    state_d   = ST_SKP;
                    skp_idx_d = '0;
`else
                    // First K28.1 goes out here; a one-symbol set is done.
                    sym_d = SYM_SKP;
                    if (SKP_LEN == 1) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d   = ST_SKP;
                        skp_idx_d = IDX_W'(1);
                    end
`endif
                end else if (transfer) begin
                    sym_d.data       = up_data;
                    sym_d.is_control = up_k;
                    sym_d.com        = up_k && (up_data == K28_5);
                    sym_d.valid      = 1'b1;
                    sym_d.skp_active = 1'b0;
                    sym_cnt_d        = sym_cnt_q + CNT_W'(1);
                end else begin
                    sym_d     = SYM_IDLE;
                    sym_cnt_d = sym_cnt_q + CNT_W'(1);
                end
            end

            ST_SKP: begin
                // tx_en is deliberately ignored: a started set always completes.
                sym_d = SYM_SKP;
                if (skp_idx_q == IDX_LAST) begin
                    state_d = ST_DATA;
                end else begin
                    skp_idx_d = skp_idx_q + IDX_W'(1);
                end
            end

            default: state_d = ST_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from
        // the same pre-edge values, independent of statement order.
        if (rst) begin
            state_q   <= ST_OFF;
            sym_cnt_q <= '0;
            skp_idx_q <= '0;
            sym_q     <= SYM_OFF;
        end else begin
            state_q   <= state_d;
            sym_cnt_q <= sym_cnt_d;
            skp_idx_q <= skp_idx_d;
            sym_q     <= sym_d;
        end
    end

    assign tx_data       = sym_q.data;
    assign tx_is_control = sym_q.is_control;
    assign tx_com        = sym_q.com;
    assign tx_valid      = sym_q.valid;
    assign skp_active    = sym_q.skp_active;

endmodule

// File: tb/tb_tx_skp_inserter.sv
// Self-checking bench for tx_skp_inserter (SKP_INTERVAL=8, SKP_LEN=2).
// Follows SKP_COM_PREFIX_EN when compiled with it.
module tb_tx_skp_inserter;

    localparam int INTERVAL = 8;
    localparam int LEN      = 2;
`ifdef SKP_COM_PREFIX_EN
    localparam int PREFIX   = 1;
`else
    localparam int PREFIX   = 0;
`endif
    localparam int SET_LEN  = PREFIX + LEN;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_en = 1'b0;
    logic [7:0] up_data = 8'h00;
    logic       up_k = 1'b0;
    logic       up_valid = 1'b0;
    logic       up_ready;
    logic [7:0] tx_data;
    logic       tx_is_control;
    logic       tx_com;
    logic       tx_valid;
    logic       skp_active;

    always #5 clk = ~clk;

    tx_skp_inserter #(
        .SKP_INTERVAL(INTERVAL),
        .SKP_LEN     (LEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_en        (tx_en),
        .up_data      (up_data),
        .up_k         (up_k),
        .up_valid     (up_valid),
        .up_ready     (up_ready),
        .tx_data      (tx_data),
        .tx_is_control(tx_is_control),
        .tx_com       (tx_com),
        .tx_valid     (tx_valid),
        .skp_active   (skp_active)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Output stream described as: a pending queue of SKP-set symbols that
    // must drain first; otherwise data/idle while counting symbols since the
    // last set.
    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       ctl;
        logic       com;
        logic       skp;
    } sym_t;

    bit   m_run = 0;
    int   m_cnt = 0;
    sym_t m_set[$];
    sym_t m_out;
    logic last_ready;

    function automatic sym_t mk(logic v, logic [7:0] d, logic c, logic cm, logic s);
        sym_t t;
        t.valid = v; t.data = d; t.ctl = c; t.com = cm; t.skp = s;
        return t;
    endfunction

    function automatic logic model_ready(logic r, logic en);
        return !r && en && m_run && (m_set.size() == 0) && (m_cnt != INTERVAL);
    endfunction

    task automatic model_update(input logic r, input logic en, input logic v,
                                input logic k, input logic [7:0] d);
        logic rdy;
        rdy = model_ready(r, en);
        if (r) begin
            m_run = 0; m_cnt = 0; m_set.delete();
            m_out = mk(0, 8'h00, 0, 0, 0);
        end else if (m_set.size() != 0) begin
            m_out = m_set.pop_front();
        end else if (!m_run) begin
            m_run = en;
            m_out = mk(0, 8'h00, 0, 0, 0);
        end else if (!en) begin
            m_run = 0;
            m_out = mk(0, 8'h00, 0, 0, 0);
        end else if (m_cnt == INTERVAL) begin
            if (PREFIX != 0) m_set.push_back(mk(1, 8'hBC, 1, 1, 1));
            for (int i = 0; i < LEN; i++) m_set.push_back(mk(1, 8'h3C, 1, 0, 1));
            m_out = m_set.pop_front();
            m_cnt = 0;
        end else if (v && rdy) begin
            m_out = mk(1, d, k, k && (d == 8'hBC), 0);
            m_cnt++;
        end else begin
            m_out = mk(1, 8'h00, 0, 0, 0);
            m_cnt++;
        end
    endtask

    // One clock: drive inputs, check combinational ready, then check the
    // registered outputs 1 ns after the edge.
    task automatic step(input logic r, input logic en, input logic v,
                        input logic k, input logic [7:0] d);
        rst = r; tx_en = en; up_valid = v; up_k = k; up_data = d;
        #2;
        last_ready = up_ready;
        check("up_ready", up_ready, model_ready(r, en));
        @(posedge clk);
        #1;
        model_update(r, en, v, k, d);
        check("tx_valid", tx_valid, m_out.valid);
        check("skp_active", skp_active, m_out.skp);
        if (m_out.valid) begin
            check("tx_data", tx_data, m_out.data);
            check("tx_is_control", tx_is_control, m_out.ctl);
            check("tx_com", tx_com, m_out.com);
        end
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 8'h00);
        check("rst_data", tx_data, 8'h00);
        check("rst_ctl", tx_is_control, 1'b0);
        check("rst_com", tx_com, 1'b0);
        check("rst_valid", tx_valid, 1'b0);
        check("rst_skp", skp_active, 1'b0);
        check("rst_ready", last_ready, 1'b0);
    endtask

    // Run with tx_en=1, up_valid=0 until the first set symbol; n_sym counts
    // the valid symbols before it.
    task automatic run_to_skp(output int n_sym);
        bit seen;
        seen  = 0;
        n_sym = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step(0, 1, 0, 0, 8'h00);
            if (skp_active) seen = 1;
            else if (tx_valid) n_sym++;
        end
        if (!seen) check("skp_timeout", skp_active, 1'b1);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       r, en, v, k;
        logic [7:0] d;
        logic       rdy;
        logic       ov;
        logic [7:0] od;
        logic       oc, ocom, oskp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(logic r, logic en, logic v, logic k, logic [7:0] d,
                                 logic rdy, logic ov, logic [7:0] od,
                                 logic oc, logic ocom, logic oskp);
        vec_t t;
        t.r = r; t.en = en; t.v = v; t.k = k; t.d = d; t.rdy = rdy;
        t.ov = ov; t.od = od; t.oc = oc; t.ocom = ocom; t.oskp = oskp;
        return t;
    endfunction

    initial begin
        int n;
        int nxt;
        int lows;
        logic [7:0] rx[$];

        // reset, enable, 8 idles, the SKP set, then K28.5 and a data byte
        tbl.push_back(mkv(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mkv(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
        for (int i = 0; i < INTERVAL; i++)
            tbl.push_back(mkv(0, 1, 0, 0, 8'h00, 1, 1, 8'h00, 0, 0, 0));
        for (int i = 0; i < SET_LEN; i++) begin
            if (PREFIX != 0 && i == 0)
                tbl.push_back(mkv(0, 1, 1, 0, 8'h11, 0, 1, 8'hBC, 1, 1, 1));
            else
                tbl.push_back(mkv(0, 1, 1, 0, 8'h11, 0, 1, 8'h3C, 1, 0, 1));
        end
        tbl.push_back(mkv(0, 1, 1, 1, 8'hBC, 1, 1, 8'hBC, 1, 1, 0));
        tbl.push_back(mkv(0, 1, 1, 0, 8'h55, 1, 1, 8'h55, 0, 0, 0));
        tbl.push_back(mkv(0, 1, 1, 1, 8'h1C, 1, 1, 8'h1C, 1, 0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].en, tbl[i].v, tbl[i].k, tbl[i].d);
            check($sformatf("tbl%0d_ready", i), last_ready, tbl[i].rdy);
            check($sformatf("tbl%0d_valid", i), tx_valid, tbl[i].ov);
            check($sformatf("tbl%0d_skp", i), skp_active, tbl[i].oskp);
            if (tbl[i].ov) begin
                check($sformatf("tbl%0d_data", i), tx_data, tbl[i].od);
                check($sformatf("tbl%0d_ctl", i), tx_is_control, tbl[i].oc);
                check($sformatf("tbl%0d_com", i), tx_com, tbl[i].ocom);
            end
        end

        // Continuous stream 0x01..0x20: in order, none lost, SET_LEN stall
        // cycles per SKP set.
        do_reset();
        step(0, 1, 0, 0, 8'h00);
        nxt  = 1;
        lows = 0;
        for (int cyc = 0; cyc < 200 && (nxt <= 32 || rx.size() < 32); cyc++) begin
            step(0, 1, nxt <= 32, 0, 8'(nxt));
            if (nxt <= 32) begin
                if (last_ready) nxt++;
                else lows++;
            end
            if (tx_valid && !skp_active && tx_data != 8'h00) rx.push_back(tx_data);
        end
        check("stream_len", rx.size(), 32);
        foreach (rx[i]) check($sformatf("stream_%0d", i), rx[i], 32'(i + 1));
        check("stream_stalls", lows, 3 * SET_LEN);

        // tx_en dropped on the first set symbol: the set still completes.
        do_reset();
        run_to_skp(n);
        check("first_interval", n, INTERVAL);
        for (int i = 1; i < SET_LEN; i++) begin
            step(0, 0, 0, 0, 8'h00);
            check("drop_rest_skp", skp_active, 1'b1);
            check("drop_rest_data", tx_data, 8'h3C);
        end
        step(0, 0, 0, 0, 8'h00);
        check("drop_off_valid", tx_valid, 1'b0);
        step(0, 1, 0, 0, 8'h00);
        check("reen_first_valid", tx_valid, 1'b0);
        run_to_skp(n);
        check("reen_interval", n, INTERVAL);

        // Reset in the middle of a SKP set.
        do_reset();
        run_to_skp(n);
        step(1, 1, 1, 0, 8'h77);
        check("midrst_data", tx_data, 8'h00);
        check("midrst_ctl", tx_is_control, 1'b0);
        check("midrst_com", tx_com, 1'b0);
        check("midrst_valid", tx_valid, 1'b0);
        check("midrst_skp", skp_active, 1'b0);
        step(0, 1, 0, 0, 8'h00);
        step(1, 1, 1, 0, 8'h77);
        check("ready_in_rst", last_ready, 1'b0);
        run_to_skp(n);
        check("midrst_interval", n, INTERVAL);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 19) != 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0,
                 ($urandom_range(0, 7) == 0) ? 8'hBC : 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
